// File: rtl/dfm_master.sv
// Bus master that runs one frequency-meter measurement: writes the gate setup, waits for the
// meter's completion pulse (or a timeout), latches the result and reads it back as 64 bits.
module dfm_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] TIMEOUT   = 32'd100_000_000
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic        start_i,
    input  logic [31:0] gate_shift_i,
    input  logic [31:0] gate_total_i,
    input  logic        signal_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] result_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_SHIFT  = 3'd1;
    localparam logic [2:0] WR_TOTAL  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] WR_LATCH  = 3'd4;
    localparam logic [2:0] RD_LO     = 3'd5;
    localparam logic [2:0] RD_HI     = 3'd6;
    localparam logic [2:0] FINISH    = 3'd7;

    logic [2:0]  r_state;
    logic [31:0] r_gate_total;
    logic        r_awvalid, r_wvalid, r_bready;
    logic        r_aw_done, r_w_done, r_b_done;
    logic [31:0] r_awaddr, r_wdata, r_araddr;
    logic        r_arvalid, r_rready;
    logic [63:0] r_result;
    logic        r_busy, r_done, r_err, r_sticky;
    logic [31:0] r_cnt;

    logic [2:0]  w_state_d;
    logic        w_aw_ok, w_w_ok, w_b_ok, w_wr_fin, w_rd_fin;
    logic        w_flag, w_tmo, w_enter, w_wr_next, w_rd_next;
    logic [31:0] w_wr_off, w_wr_data, w_rd_off;

    assign w_aw_ok   = r_aw_done | (r_awvalid & m_axi_awready);
    assign w_w_ok    = r_w_done | (r_wvalid & m_axi_wready);
    assign w_b_ok    = r_b_done | (r_bready & m_axi_bvalid);
    assign w_wr_fin  = w_aw_ok & w_w_ok & w_b_ok;
    assign w_rd_fin  = r_rready & m_axi_rvalid;
    // Sticky flag catches a completion pulse that arrived before WAIT_DONE.
    assign w_flag    = r_sticky | signal_done_i;
    assign w_tmo     = (TIMEOUT != 32'd0) && (r_cnt == TIMEOUT - 32'd1);
    assign w_enter   = (w_state_d != r_state);
    assign w_wr_next = (w_state_d == WR_SHIFT) || (w_state_d == WR_TOTAL) ||
                       (w_state_d == WR_LATCH);
    assign w_rd_next = (w_state_d == RD_LO) || (w_state_d == RD_HI);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:      if (start_i) w_state_d = WR_SHIFT;
            WR_SHIFT:  if (w_wr_fin) w_state_d = WR_TOTAL;
            WR_TOTAL:  if (w_wr_fin) w_state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (w_flag) w_state_d = WR_LATCH;
                else if (w_tmo) w_state_d = FINISH;
            end
            WR_LATCH:  if (w_wr_fin) w_state_d = RD_LO;
            RD_LO:     if (w_rd_fin) w_state_d = RD_HI;
            RD_HI:     if (w_rd_fin) w_state_d = FINISH;
            FINISH:    w_state_d = IDLE;
            default:   w_state_d = IDLE;
        endcase
    end

    // WR_SHIFT is only entered from IDLE, so the live gate_shift_i is the captured value.
    always_comb begin
        w_wr_off  = 32'h0;
        w_wr_data = 32'h0;
        w_rd_off  = 32'h8;
        case (w_state_d)
            WR_SHIFT: w_wr_data = gate_shift_i;
            WR_TOTAL: begin
                w_wr_off  = 32'h4;
                w_wr_data = r_gate_total;
            end
            WR_LATCH: w_wr_off = 32'h10;
            RD_HI:    w_rd_off = 32'hC;
            default:  ;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state      <= IDLE;
            r_gate_total <= 32'h0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_b_done     <= 1'b0;
            r_awaddr     <= 32'h0;
            r_wdata      <= 32'h0;
            r_araddr     <= 32'h0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_result     <= 64'h0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_sticky     <= 1'b0;
            r_cnt        <= 32'h0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d != IDLE);
            r_done  <= (w_state_d == FINISH);

            if (r_state == IDLE && start_i) begin
                r_gate_total <= gate_total_i;
                r_sticky     <= 1'b0;
                r_err        <= 1'b0;
            end else begin
                if (r_state != IDLE && signal_done_i) r_sticky <= 1'b1;
                if (r_state == WAIT_DONE && !w_flag && w_tmo) r_err <= 1'b1;
            end

            if (w_enter && w_state_d == WAIT_DONE) r_cnt <= 32'h0;
            else if (r_state == WAIT_DONE) r_cnt <= r_cnt + 32'd1;

            if (w_enter && w_wr_next) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_bready  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_b_done  <= 1'b0;
                r_awaddr  <= BASE_ADDR + w_wr_off;
                r_wdata   <= w_wr_data;
            end else if (!w_wr_next) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
            end else begin
                if (m_axi_awready) r_awvalid <= 1'b0;
                if (m_axi_wready) r_wvalid <= 1'b0;
                if (m_axi_bvalid) r_bready <= 1'b0;
                r_aw_done <= w_aw_ok;
                r_w_done  <= w_w_ok;
                r_b_done  <= w_b_ok;
            end

            if (w_enter && w_rd_next) begin
                r_arvalid <= 1'b1;
                r_rready  <= 1'b1;
                r_araddr  <= BASE_ADDR + w_rd_off;
            end else if (!w_rd_next) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
            end else begin
                if (m_axi_arready) r_arvalid <= 1'b0;
                if (m_axi_rvalid) r_rready <= 1'b0;
            end

            if (w_rd_fin && r_state == RD_LO) r_result[31:0] <= m_axi_rdata;
            if (w_rd_fin && r_state == RD_HI) r_result[63:32] <= m_axi_rdata;
        end
    end

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign result_o      = r_result;

endmodule

// File: tb/tb_dfm_master.sv
// Bench for dfm_master: programmable-delay bus responder, transaction scoreboard and timing checks.
module tb_dfm_master;

    logic        m_axi_aclk = 1'b0;
    logic        m_axi_aresetn;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic        start_i = 1'b0;
    logic        signal_done_i = 1'b0;
    logic [31:0] gate_shift_i, gate_total_i;
    logic        busy_o, done_o, err_o;
    logic [63:0] result_o;

    dfm_master #(
        .BASE_ADDR(32'h0000_0000),
        .TIMEOUT  (32'd100)
    ) dut (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_aresetn(m_axi_aresetn),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .start_i      (start_i),
        .gate_shift_i (gate_shift_i),
        .gate_total_i (gate_total_i),
        .signal_done_i(signal_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .result_o     (result_o)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    int cyc = 0;
    always @(posedge m_axi_aclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];

    task automatic push_meas(input logic [31:0] sh, input logic [31:0] tot, input bit full);
        exp_q.push_back('{wr: 1'b1, addr: 32'h00, data: sh});
        exp_q.push_back('{wr: 1'b1, addr: 32'h04, data: tot});
        if (full) begin
            exp_q.push_back('{wr: 1'b1, addr: 32'h10, data: 32'h0});
            exp_q.push_back('{wr: 1'b0, addr: 32'h08, data: 32'h0});
            exp_q.push_back('{wr: 1'b0, addr: 32'h0C, data: 32'h0});
        end
    endtask

    task automatic sb_pop(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_txn", {32'h0, addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_kind", wr, e.wr);
            check_eq("sb_addr", addr, e.addr);
            if (wr) check_eq("sb_wdata", data, e.data);
        end
    endtask

    // Responder: each ready rises once its valid has waited the programmed number of cycles.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt;
    logic aw_got, w_got, r_pend;
    logic [31:0] r_addr, rd_lo, rd_hi;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
    assign m_axi_bvalid  = aw_got && w_got && (b_cnt >= b_dly);
    assign m_axi_arready = m_axi_arvalid && !r_pend && (ar_cnt >= ar_dly);
    assign m_axi_rvalid  = r_pend;
    assign m_axi_rdata   = !r_pend ? 32'h0 : (r_addr == 32'h08) ? rd_lo :
                           (r_addr == 32'h0C) ? rd_hi : 32'hDEAD_BEEF;

    always @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; r_addr <= 32'h0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            if (m_axi_bvalid && m_axi_bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else begin
                if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
                if (m_axi_wvalid && m_axi_wready) w_got <= 1'b1;
                if (aw_got && w_got) b_cnt <= b_cnt + 1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                r_pend <= 1'b1; r_addr <= m_axi_araddr;
            end else if (r_pend && m_axi_rready) begin
                r_pend <= 1'b0;
            end
        end
    end

    int st_a = -1, st_b = -1, st_c = -1, sd_cycle = -1;
    initial begin : drive
        forever begin
            @(posedge m_axi_aclk);
            #1;
            start_i       = (cyc == st_a) || (cyc == st_b) || (cyc == st_c);
            signal_done_i = (cyc == sd_cycle);
        end
    end

    int t_aw[$], t_b[$];
    int t_done = -1, n_done = 0;
    logic m_aw_got = 1'b0, m_w_got = 1'b0;
    logic [31:0] m_aw_addr, m_w_data, p_awaddr, p_wdata;
    logic p_aw_hs = 1'b0, p_w_hs = 1'b0, p_ar_hs = 1'b0, p_awvalid = 1'b0, p_wvalid = 1'b0;

    function automatic int aw_at(input int i);
        return (i < t_aw.size()) ? t_aw[i] : -1;
    endfunction
    function automatic int b_at(input int i);
        return (i < t_b.size()) ? t_b[i] : -1;
    endfunction

    initial begin : monitor
        logic aw_hs, w_hs, ar_hs;
        forever begin
            @(negedge m_axi_aclk);
            if (!m_axi_aresetn) begin
                m_aw_got = 1'b0; m_w_got = 1'b0;
                p_aw_hs = 1'b0; p_w_hs = 1'b0; p_ar_hs = 1'b0;
                p_awvalid = 1'b0; p_wvalid = 1'b0;
            end else begin
                aw_hs = m_axi_awvalid && m_axi_awready;
                w_hs  = m_axi_wvalid && m_axi_wready;
                ar_hs = m_axi_arvalid && m_axi_arready;
                if (p_aw_hs) check_eq("awvalid_drop", m_axi_awvalid, 1'b0);
                if (p_w_hs) check_eq("wvalid_drop", m_axi_wvalid, 1'b0);
                if (p_ar_hs) check_eq("arvalid_drop", m_axi_arvalid, 1'b0);
                if (p_awvalid && !p_aw_hs && m_axi_awvalid)
                    check_eq("awaddr_stable", m_axi_awaddr, p_awaddr);
                if (p_wvalid && !p_w_hs && m_axi_wvalid)
                    check_eq("wdata_stable", m_axi_wdata, p_wdata);
                if (m_axi_awvalid && !p_awvalid) t_aw.push_back(cyc);
                if (m_axi_bvalid && m_axi_bready) t_b.push_back(cyc);
                if (aw_hs) begin m_aw_got = 1'b1; m_aw_addr = m_axi_awaddr; end
                if (w_hs) begin m_w_got = 1'b1; m_w_data = m_axi_wdata; end
                if (m_aw_got && m_w_got) begin
                    sb_pop(1'b1, m_aw_addr, m_w_data);
                    m_aw_got = 1'b0; m_w_got = 1'b0;
                end
                if (ar_hs) sb_pop(1'b0, m_axi_araddr, 32'h0);
                if (done_o) begin n_done++; t_done = cyc; end
                p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
                p_awvalid = m_axi_awvalid; p_wvalid = m_axi_wvalid;
                p_awaddr = m_axi_awaddr; p_wdata = m_axi_wdata;
            end
        end
    end

    task automatic clear_log();
        t_aw.delete();
        t_b.delete();
        t_done = -1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base = n_done;
        int k = 0;
        while (n_done == base && k < budget) begin
            @(negedge m_axi_aclk);
            #1;
            k++;
        end
        check_eq(tag, n_done - base, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0, base;
        m_axi_aresetn = 1'b1;
        gate_shift_i = 32'h0; gate_total_i = 32'h0;
        rd_lo = 32'h0; rd_hi = 32'h0;
        #1 m_axi_aresetn = 1'b0;
        repeat (2) @(negedge m_axi_aclk);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                m_axi_arvalid, m_axi_rready}, 5'b0);
        check_eq("rst_result", result_o, 64'h0);
        check_eq("rst_awaddr", m_axi_awaddr, 32'h0);
        @(posedge m_axi_aclk);
        #1 m_axi_aresetn = 1'b1;

        // Zero-wait run: 2 cycles per transfer, done 7 cycles after the completion pulse.
        gate_shift_i = 32'd5; gate_total_i = 32'd1000;
        rd_lo = 32'h1234; rd_hi = 32'hABCD;
        push_meas(32'd5, 32'd1000, 1'b1);
        clear_log();
        base = n_done;
        n0 = cyc + 2; st_a = n0; sd_cycle = n0 + 50;
        wait_done(200, "t1_done_seen");
        check_eq("t1_awvalid_lat", aw_at(0), n0 + 1);
        check_eq("t1_b0_lat", b_at(0), n0 + 2);
        check_eq("t1_b1_lat", b_at(1), n0 + 4);
        check_eq("t1_done_lat", t_done, n0 + 57);
        check_eq("t1_result", result_o, 64'h0000ABCD_00001234);
        check_eq("t1_err", err_o, 1'b0);
        repeat (5) @(negedge m_axi_aclk);
        check_eq("t1_one_done", n_done - base, 1);
        check_eq("t1_idle", busy_o, 1'b0);
        check_eq("t1_sb_empty", exp_q.size(), 0);

        // Slow responder: wready 3 cycles before awready, bvalid 4 cycles late.
        aw_dly = 3; w_dly = 0; b_dly = 4;
        gate_shift_i = 32'd7; gate_total_i = 32'd2000;
        rd_lo = 32'h5555_0001; rd_hi = 32'h0000_7777;
        push_meas(32'd7, 32'd2000, 1'b1);
        clear_log();
        n0 = cyc + 2; st_a = n0; sd_cycle = n0 + 40;
        wait_done(300, "t2_done_seen");
        check_eq("t2_b0_wait", b_at(0), aw_at(0) + 8);
        check_eq("t2_no_early_adv", aw_at(1), aw_at(0) + 9);
        check_eq("t2_result", result_o, 64'h0000_7777_5555_0001);
        check_eq("t2_err", err_o, 1'b0);
        check_eq("t2_sb_empty", exp_q.size(), 0);
        aw_dly = 0; w_dly = 0; b_dly = 0;

        // Timeout: no completion pulse; FINISH follows the 100th WAIT_DONE cycle.
        gate_shift_i = 32'd9; gate_total_i = 32'd3;
        push_meas(32'd9, 32'd3, 1'b0);
        clear_log();
        n0 = cyc + 2; st_a = n0; sd_cycle = -1;
        wait_done(300, "t3_done_seen");
        check_eq("t3_tmo_lat", t_done, b_at(1) + 101);
        check_eq("t3_err", err_o, 1'b1);
        check_eq("t3_result_kept", result_o, 64'h0000_7777_5555_0001);
        repeat (5) @(negedge m_axi_aclk);
        check_eq("t3_err_hold", err_o, 1'b1);
        check_eq("t3_no_reads", exp_q.size(), 0);

        // Completion pulse during WR_TOTAL is remembered.
        gate_shift_i = 32'd11; gate_total_i = 32'd22;
        rd_lo = 32'h0000_AAAA; rd_hi = 32'h0000_BBBB;
        push_meas(32'd11, 32'd22, 1'b1);
        clear_log();
        n0 = cyc + 2; st_a = n0; sd_cycle = n0 + 3;
        wait_done(100, "t4_done_seen");
        check_eq("t4_latch_lat", aw_at(2), b_at(1) + 2);
        check_eq("t4_done_lat", t_done, n0 + 12);
        check_eq("t4_err_cleared", err_o, 1'b0);
        check_eq("t4_result", result_o, 64'h0000BBBB_0000AAAA);

        // Extra starts in WAIT_DONE and FINISH are ignored.
        gate_shift_i = 32'd1; gate_total_i = 32'd2;
        rd_lo = 32'h1111; rd_hi = 32'h2222;
        push_meas(32'd1, 32'd2, 1'b1);
        clear_log();
        base = n_done;
        n0 = cyc + 2; st_a = n0; st_b = n0 + 10; st_c = n0 + 27; sd_cycle = n0 + 20;
        wait_done(100, "t5_done_seen");
        check_eq("t5_done_lat", t_done, n0 + 27);
        repeat (15) @(negedge m_axi_aclk);
        check_eq("t5_one_meas", n_done - base, 1);
        check_eq("t5_idle", busy_o, 1'b0);
        check_eq("t5_sb_empty", exp_q.size(), 0);
        check_eq("t5_result", result_o, 64'h00002222_00001111);
        st_b = -1; st_c = -1;

        // Asynchronous reset while arvalid waits in RD_LO.
        gate_shift_i = 32'd3; gate_total_i = 32'd4;
        ar_dly = 5;
        push_meas(32'd3, 32'd4, 1'b1);
        clear_log();
        n0 = cyc + 2; st_a = n0; sd_cycle = n0 + 10;
        while (cyc < n0 + 14) @(negedge m_axi_aclk);
        #2;
        check_eq("t6_pre_arvalid", m_axi_arvalid, 1'b1);
        m_axi_aresetn = 1'b0;
        #1;
        check_eq("t6_arvalid_async", m_axi_arvalid, 1'b0);
        check_eq("t6_busy_async", busy_o, 1'b0);
        check_eq("t6_result_async", result_o, 64'h0);
        exp_q.delete();
        ar_dly = 0; sd_cycle = -1;
        repeat (2) @(posedge m_axi_aclk);
        #1 m_axi_aresetn = 1'b1;

        gate_shift_i = 32'd5; gate_total_i = 32'd1000;
        rd_lo = 32'h1234; rd_hi = 32'hABCD;
        push_meas(32'd5, 32'd1000, 1'b1);
        clear_log();
        n0 = cyc + 2; st_a = n0; sd_cycle = n0 + 30;
        wait_done(200, "t6_done_seen");
        check_eq("t6_awvalid_lat", aw_at(0), n0 + 1);
        check_eq("t6_done_lat", t_done, n0 + 37);
        check_eq("t6_result", result_o, 64'h0000ABCD_00001234);
        check_eq("t6_err", err_o, 1'b0);
        repeat (3) @(negedge m_axi_aclk);
        check_eq("t6_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dfm_master.md
DFM_MASTER -- requirements
Module: dfm_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the meter register base; every address issued is BASE_ADDR + offset.
REQ-002 Parameter TIMEOUT, default 32'd100_000_000, is the maximum number of cycles spent waiting for measurement completion; a value of 0 disables the timeout.
REQ-003 Port m_axi_aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port m_axi_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Ports m_axi_awaddr (output, 32), m_axi_awvalid (output, 1) and m_axi_awready (input, 1) form the write-address channel.
REQ-006 Ports m_axi_wdata (output, 32), m_axi_wvalid (output, 1) and m_axi_wready (input, 1) form the write-data channel.
REQ-007 Ports m_axi_bvalid (input, 1) and m_axi_bready (output, 1) form the write-response channel; there is no response code.
REQ-008 Ports m_axi_araddr (output, 32), m_axi_arvalid (output, 1) and m_axi_arready (input, 1) form the read-address channel.
REQ-009 Ports m_axi_rdata (input, 32), m_axi_rvalid (input, 1) and m_axi_rready (output, 1) form the read-data channel.
REQ-010 Port start_i, input, 1 bit: single-cycle request to run one measurement.
REQ-011 Ports gate_shift_i and gate_total_i, inputs, 32 bits each: measurement configuration, sampled on an accepted start.
REQ-012 Port signal_done_i, input, 1 bit: the meter's completion pulse.
REQ-013 Port busy_o, output, 1 bit: high in every state except IDLE.
REQ-014 Port done_o, output, 1 bit: single-cycle completion pulse.
REQ-015 Port err_o, output, 1 bit: timeout flag, valid whenever done_o is high.
REQ-016 Port result_o, output, 64 bits: last measurement result, {high word, low word}.

Function
REQ-017 The FSM SHALL use these states: IDLE, WR_SHIFT, WR_TOTAL, WAIT_DONE, WR_LATCH, RD_LO, RD_HI, FINISH.
REQ-018 In IDLE, start_i=1 SHALL capture gate_shift_i and gate_total_i, clear the sticky done flag, and enter WR_SHIFT; start_i in any other state SHALL be ignored.
REQ-019 Each write state SHALL assert awvalid and wvalid together in the first cycle after entering the state; address and data SHALL stay stable while valid is high.
- awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high, independently.
- bready is high from the state's first cycle until bvalid is sampled high.
- The state advances only after all three handshakes (AW, W, B) have completed, in any order, including all in the same cycle.
REQ-020 The write sequence SHALL be:
- WR_SHIFT: offset 0x00, data = gate_shift; then WR_TOTAL.
- WR_TOTAL: offset 0x04, data = gate_total; then WAIT_DONE.
- WR_LATCH: offset 0x10, data = 32'h0; then RD_LO. This write copies the meter's result into its readable register.
REQ-021 A sticky flag SHALL set on any signal_done_i=1 seen while busy.
- WAIT_DONE exits to WR_LATCH on the first cycle the flag (or signal_done_i) is high, so a pulse arriving during WR_TOTAL is not lost.
REQ-022 In WAIT_DONE, a 32-bit cycle counter (cleared on entry) reaching TIMEOUT (TIMEOUT≠0) SHALL set err and enter FINISH without touching result_o.
REQ-023 Each read state SHALL assert arvalid in its first cycle and hold it until arready is sampled high; rready is high from the state's first cycle until rvalid is sampled high.
- RD_LO: offset 0x08; the rdata accepted with rvalid loads result_o[31:0].
- RD_HI: offset 0x0C; the rdata accepted with rvalid loads result_o[63:32].
REQ-024 The read states SHALL advance on rvalid&&rready; arready and rvalid in the same cycle SHALL be legal.
REQ-025 FINISH SHALL last exactly one cycle with done_o=1 (err_o=0 on success), then return to IDLE; err_o holds until the next accepted start.
REQ-026 Best-case latency SHALL be: start at cycle N gives awvalid at N+1; with a zero-wait responder (handshake in the first valid cycle, response the next cycle), each transfer takes 2 cycles.
REQ-027 Valid/ready outputs SHALL never depend combinationally on inputs; all are registered.

Reset
REQ-028 On m_axi_aresetn=0, asynchronously and in any state:
- FSM returns to IDLE.
- All valid/ready outputs, busy_o, done_o and err_o = 0.
- result_o, addresses and wdata = 0.
- Counters and the sticky flag are cleared.
An in-flight transaction is abandoned.

Verification
REQ-029 Zero-wait responder model, BASE_ADDR=0; start with shift=5, total=1000; signal_done after 50 cycles; rdata 0x08=0x1234, 0x0C=0xABCD -> writes 0x00=5, 0x04=1000, 0x10=0, then reads 0x08, 0x0C; done_o one pulse; result_o=64'h0000ABCD_00001234; err_o=0.
REQ-030 Responder asserting wready 3 cycles before awready, and bvalid delayed 4 cycles -> each valid drops independently after its own handshake; no state advance before bvalid.
REQ-031 TIMEOUT=100 with signal_done never asserted -> done_o at the 100th WAIT_DONE cycle; err_o=1; result_o keeps its prior value; no WR_LATCH or reads issued.
REQ-032 signal_done_i pulsed during WR_TOTAL -> WR_LATCH begins immediately after the WR_TOTAL B handshake.
REQ-033 start_i pulsed in WAIT_DONE and FINISH -> ignored; exactly one measurement occurs.
REQ-034 Reset asserted mid-RD_LO with arvalid=1 -> arvalid, busy_o and result_o go 0 without waiting for a clock edge; a following start runs a clean sequence.
